// File: rtl/flp_sig_add_norm_round_if.sv
// Handshake and data bundle for the significand add / normalize / round back half.
interface flp_sig_add_norm_round_if #(
   parameter int EXP_BITS = 8,
   parameter int SIG_BITS = 23,
   parameter int TAG_BITS = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic                         round_mode;
   logic                         sign_result;
   logic                         eff_sub;
   logic                         zero_a;
   logic [EXP_BITS-1:0]          exp_b;
   logic [SIG_BITS:0]            sig_b;
   logic [SIG_BITS:0]            sig_a;
   logic [2:0]                   grs_a;
   logic [TAG_BITS-1:0]          tag_in;
   logic                         out_valid;
   logic                         out_ready;
   logic [EXP_BITS+SIG_BITS:0]   result;
   logic [TAG_BITS-1:0]          tag_out;
   logic                         flag_overflow;
   logic                         flag_inexact;

   modport master (
      output in_valid, round_mode, sign_result, eff_sub, zero_a, exp_b, sig_b, sig_a,
             grs_a, tag_in, out_ready,
      input  in_ready, out_valid, result, tag_out, flag_overflow, flag_inexact
   );

   modport slave (
      input  in_valid, round_mode, sign_result, eff_sub, zero_a, exp_b, sig_b, sig_a,
             grs_a, tag_in, out_ready,
      output in_ready, out_valid, result, tag_out, flag_overflow, flag_inexact
   );
endinterface

// File: rtl/flp_sig_add_norm_round.sv
// Five-stage significand add, normalize (incl. subnormals), round (RNE/RTZ) and pack.
// Stages: add -> leading-zero count -> shift -> round -> pack. One global stall.
module flp_sig_add_norm_round #(
   parameter int EXP_BITS = 8,
   parameter int SIG_BITS = 23,
   parameter int TAG_BITS = 4
) (
   input logic                     clk,
   input logic                     rst,
   flp_sig_add_norm_round_if.slave bus
);
   localparam int W   = SIG_BITS + 5;   // carry + hidden + fraction + G/R/S
   localparam int SW  = SIG_BITS + 1;   // significand incl. hidden bit
   localparam int EW  = EXP_BITS + 1;   // exponent with headroom for overflow detection
   localparam int LZW = $clog2(W);
   localparam int SBW = TAG_BITS + 2;   // sideband: {sign, round_mode, tag}

   logic adv;
   logic s1_valid, s2_valid, s3_valid, s4_valid, s5_valid;
   logic [SBW-1:0] s1_sb, s2_sb, s3_sb, s4_sb;

   logic [W-1:0]          s1_sum;
   logic [EXP_BITS-1:0]   s1_exp;
   logic [W-2:0]          s2_sig, s3_sig;
   logic [EW-1:0]         s2_exp, s3_exp, s4_exp;
   logic [LZW-1:0]        s2_shift;
   logic                  s2_zero, s3_zero, s4_zero;
   logic [SW-1:0]         s4_sig;
   logic                  s4_inx;

   logic [EXP_BITS+SIG_BITS:0] result_q;
   logic [TAG_BITS-1:0]        tag_q;
   logic                       ovf_q, inx_q;

   assign adv           = ~(s5_valid & ~bus.out_ready);
   assign bus.in_ready  = adv;
   assign bus.out_valid = s5_valid;
   assign bus.result    = result_q;
   assign bus.tag_out   = tag_q;
   assign bus.flag_overflow = ovf_q;
   assign bus.flag_inexact  = inx_q;

   // add: B +/- A at full width, upstream guarantees B >= A so no sign flip
   logic [W-1:0] a_ext, b_ext, sum_c;
   always_comb begin
      a_ext = bus.zero_a ? '0 : {1'b0, bus.sig_a, bus.grs_a};
      b_ext = {1'b0, bus.sig_b, 3'b000};
      sum_c = bus.eff_sub ? b_ext - a_ext : b_ext + a_ext;
   end

   // leading-zero count and shift amount; a carry is handled here by a sticky right shift
   logic [LZW-1:0] lz_c, nshift_c;
   logic [W-2:0]   nsig_c;
   logic [EW-1:0]  nexp_c, lim_c;
   always_comb begin
      lz_c = LZW'(W - 1);
      for (int i = 0; i < W - 1; i++)
         if (s1_sum[i]) lz_c = LZW'(W - 2 - i);
      lim_c    = {1'b0, s1_exp} - EW'(1);
      nshift_c = '0;
      if (s1_sum[W-1]) begin
         nsig_c = {s1_sum[W-1:2], |s1_sum[1:0]};
         nexp_c = {1'b0, s1_exp} + EW'(1);
      end else begin
         nsig_c = s1_sum[W-2:0];
         nexp_c = {1'b0, s1_exp};
         // never shift below the minimum normal exponent; the rest stays subnormal
         if (s1_exp != '0)
            nshift_c = (EW'(lz_c) < lim_c) ? lz_c : LZW'(lim_c);
      end
   end

   // shift: exponent drops to 0 when the hidden position did not fill
   logic [W-2:0]  shifted_c;
   logic [EW-1:0] sexp_c;
   always_comb begin
      shifted_c = s2_sig << s2_shift;
      sexp_c    = shifted_c[W-2] ? s2_exp - EW'(s2_shift) : '0;
   end

   // round: RNE increments on G & (R | S | LSB); RTZ truncates
   logic          g_c, r_c, s_c, inc_c;
   logic [SW:0]   rnd_c;
   logic [SW-1:0] rsig_c;
   logic [EW-1:0] rexp_c;
   always_comb begin
      g_c    = s3_sig[2];
      r_c    = s3_sig[1];
      s_c    = s3_sig[0];
      inc_c  = ~s3_sb[SBW-2] & g_c & (r_c | s_c | s3_sig[3]);
      rnd_c  = {1'b0, s3_sig[W-2:3]} + {{SW{1'b0}}, inc_c};
      rsig_c = rnd_c[SW-1:0];
      rexp_c = s3_exp;
      if (rnd_c[SW]) begin
         rsig_c = {1'b1, {SIG_BITS{1'b0}}};
         rexp_c = s3_exp + EW'(1);
      end else if (s3_exp == '0 && rnd_c[SW-1]) begin
         // a subnormal (or exp_b = 0 sum) that reaches the hidden bit becomes normal
         rexp_c = EW'(1);
      end
   end

   // pack: exact zero wins, then overflow saturates to inf (RNE) or max finite (RTZ)
   logic                       ovf_c, pinx_c;
   logic [EXP_BITS+SIG_BITS:0] pres_c;
   always_comb begin
      ovf_c  = s4_exp >= {1'b0, {EXP_BITS{1'b1}}};
      pinx_c = s4_inx;
      pres_c = {s4_sb[SBW-1], s4_exp[EXP_BITS-1:0], s4_sig[SIG_BITS-1:0]};
      if (s4_zero) begin
         ovf_c  = 1'b0;
         pinx_c = 1'b0;
         pres_c = '0;
      end else if (ovf_c) begin
         pinx_c = 1'b1;
         if (s4_sb[SBW-2])
            pres_c = {s4_sb[SBW-1], {(EXP_BITS-1){1'b1}}, 1'b0, {SIG_BITS{1'b1}}};
         else
            pres_c = {s4_sb[SBW-1], {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
      end
   end

   // valid chain: cleared by reset, advances whenever the output is not stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s4_valid <= 1'b0;
         s5_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         s4_valid <= s3_valid;
         s5_valid <= s4_valid;
      end
   end

   // datapath registers for stages 1-4, held together on stall
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_sum   <= sum_c;
         s1_exp   <= bus.exp_b;
         s1_sb    <= {bus.sign_result, bus.round_mode, bus.tag_in};
         s2_sig   <= nsig_c;
         s2_exp   <= nexp_c;
         s2_shift <= nshift_c;
         s2_zero  <= (s1_sum == '0);
         s2_sb    <= s1_sb;
         s3_sig   <= shifted_c;
         s3_exp   <= sexp_c;
         s3_zero  <= s2_zero;
         s3_sb    <= s2_sb;
         s4_sig   <= rsig_c;
         s4_exp   <= rexp_c;
         s4_inx   <= g_c | r_c | s_c;
         s4_zero  <= s3_zero;
         s4_sb    <= s3_sb;
      end
   end

   // visible output registers; only a real result overwrites them
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         tag_q    <= '0;
         ovf_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else if (adv && s4_valid) begin
         result_q <= pres_c;
         tag_q    <= s4_sb[TAG_BITS-1:0];
         ovf_q    <= ovf_c;
         inx_q    <= pinx_c;
      end
   end
endmodule

// File: doc/flp_sig_add_norm_round.md
Name: flp_sig_add_norm_round

Overview:
- Parametrised successor to the floating-point adder's significand-add/renormalize back half.
- Adds or subtracts two pre-aligned significands, normalizes (including subnormal results), rounds using guard/round/sticky bits under a selectable rounding mode, and packs the IEEE-style result.
- Adds valid/ready backpressure, a tag passthrough, and overflow/inexact flags.
- Sits after the exponent-compare/alignment stage of the adder.

Parameters:
EXP_BITS, 8, exponent field width
SIG_BITS, 23, stored fraction width (hidden bit excluded)
TAG_BITS, 4, opaque sideband carried alongside each operation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input operation valid
in_ready  out  1  block accepts input this cycle
round_mode  in  1  0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ)
sign_result  in  1  sign of larger-magnitude operand
eff_sub  in  1  1 = effective subtraction (sig_b - a), 0 = addition
zero_a  in  1  aligned a fully underflowed; treat a (incl. grs_a) as 0
exp_b  in  EXP_BITS  biased exponent of larger operand; never all-ones
sig_b  in  SIG_BITS+1  larger significand incl. hidden bit
sig_a  in  SIG_BITS+1  smaller significand after right alignment
grs_a  in  3  guard, round, sticky bits shifted out of sig_a
tag_in  in  TAG_BITS  sideband
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  EXP_BITS+SIG_BITS+1  {sign, exponent, fraction}
tag_out  out  TAG_BITS  tag_in of this result
flag_overflow  out  1  result exponent overflowed
flag_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset values: out_valid=0, result=0, tag_out=0, flags=0. All pipeline valid bits clear one cycle after rst is high. Data registers need not reset. In-flight operations are discarded.
- Pipeline:
  - Fixed 5 register stages, in order: add, LZC, shift, round, pack.
  - Latency is 5 cycles from an accepted input to out_valid when unstalled.
  - Throughput is 1 operation per cycle.
- Handshake:
  - Global stall: stall = out_valid & ~out_ready. All stages hold while stalled.
  - in_ready = ~stall. Input is accepted when in_valid & in_ready.
  - Results leave in acceptance order, and result/tag_out/flags stay stable while stalled.
  - Bubbles (invalid slots) propagate without stalling.
- Add:
  - A = {sig_a, grs_a}, or 0 if zero_a. B = {sig_b, 3'b000}.
  - sum = B + A or B - A, computed at width SIG_BITS+5 (carry bit included).
  - Upstream guarantees B >= A.
- Normalize:
  - If carry is set: shift right 1, OR the dropped bit into sticky, exp = exp_b + 1.
  - Else, with lz = leading zeros of sum excluding the carry bit:
    - exp_b >= 1: shift left by min(lz, exp_b - 1).
    - exp_b = 0: no shift.
  - Exponent after a left shift:
    - Leading bit set: exp = exp_b - shift.
    - Otherwise exp = 0 (subnormal).
  - Sticky stays LSB-ORed.
- Round:
  - RNE: increment when G & (R | S | LSB).
  - RTZ: never increment.
  - inexact = G | R | S after normalization.
  - Increment carry-out renormalizes the significand to 1.0 and sets exp += 1.
  - Subnormal rounding into the hidden bit sets exp = 1.
- Overflow (exp reaches all-ones):
  - flag_overflow = 1 and flag_inexact = 1.
  - RNE: result = infinity ({sign, all-ones, 0}).
  - RTZ: result = max finite ({sign, all-ones-1, all-ones fraction}).
- Zero: an exact zero sum gives result = +0 (sign 0) regardless of sign_result or round_mode, with flags 0.
- Fraction output is the significand without the hidden bit.

Test Plan:
- Single-precision 1.0+1.0: exp_b=127, sig_b=sig_a=0x800000, grs_a=0, eff_sub=0, RNE → result=0x40000000 exactly 5 cycles after acceptance, flags 0.
- 1.0-1.0 (eff_sub=1, sign_result=1) → result=0x00000000, flag_inexact=0. A separate case with exp_b=1, sig_b=0x800000, sig_a=0x400000, eff_sub=1 → subnormal result=0x00400000.
- Tie rounding: sig_b=0x800000, sig_a=0, grs_a=3'b100, exp_b=127:
  - RNE → 0x3F800000, inexact=1.
  - With sig_a=1 and the same grs_a, RNE → 0x3F800002.
  - The sig_a=1 case under RTZ → 0x3F800001.
- Overflow: exp_b=254, sig_b=sig_a=0xFFFFFF, eff_sub=0 → RNE 0x7F800000, RTZ 0x7F7FFFFF, flag_overflow=1 in both.
- Backpressure: stream 8 back-to-back ops with tags 0..7 and drop out_ready for 3 cycles mid-stream → in_ready low exactly while stalled, result held stable, all 8 delivered in tag order, none duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 ops in flight → out_valid=0 the next cycle, and no stale results appear after new inputs.
